mult_share_ctrl: RTL and testbench
==================================

# mult_share_ctrl

Round-robin controller that shares one multi-cycle signed Booth multiplier core (ports en, A, B, done, M) between NREQ requesters. Each requester presents a pair of signed operands with a valid/ready handshake. The controller grants one requester at a time, sequences the core through a single operation, and returns the product tagged with the requester ID on a valid/ready response channel. A watchdog detects a core that never signals done.

## Interface
- WIDTH, 8: operand width; product is 2*WIDTH bits.
- NREQ, 4: number of requesters (2..16).
- IDW, 2: requester ID width, equal to clog2(NREQ).
- TIMEOUT, 64: maximum WAIT cycles before fault; must exceed WIDTH+3.

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  NREQ  per-requester operand valid
- req_a  in  NREQ*WIDTH  packed signed operand A; slice i belongs to requester i
- req_b  in  NREQ*WIDTH  packed signed operand B
- req_ready  out  NREQ  one-hot grant/accept
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result accepted
- rsp_id  out  IDW  requester ID of the result
- rsp_m  out  2*WIDTH  signed product
- rsp_err  out  1  result is a timeout abort; rsp_m is 0
- fault  out  1  sticky core-timeout flag
- mult_en  out  1  core enable
- mult_a, mult_b  out  WIDTH  core operands, held stable for the whole operation
- mult_done  in  1  core done flag; can be stale high while idle
- mult_m  in  2*WIDTH  core product, valid while mult_done=1

## Operation
- States: IDLE, ISSUE, WAIT, RESP, HALT.
- IDLE: if fault=0 and any req_valid is set, grant the first set bit at or after pointer ptr, wrapping modulo NREQ.
  - Assert req_ready[g] combinationally in that cycle.
  - Latch the slices g of req_a/req_b into mult_a/mult_b and latch the ID.
  - Set ptr <= (g+1) mod NREQ. Next state: ISSUE.
- req_ready is 0 in every state other than IDLE. At most one bit is ever high.
- ISSUE (exactly 1 cycle): mult_en=1. mult_done is ignored because it can be stale from the previous operation. Next state: WAIT.
- WAIT: mult_en = ~mult_done.
  - When mult_done=1: capture mult_m into rsp_m, set rsp_err=0, go to RESP.
  - When the wait counter reaches TIMEOUT first: set rsp_m=0, rsp_err=1, fault=1, mult_en=0, go to RESP.
- RESP: rsp_valid=1; rsp_id, rsp_m and rsp_err are held stable until rsp_ready=1.
  - On acceptance, go to HALT if fault=1, otherwise IDLE.
- HALT: terminal state; no further grants. Only rst_n exits it.
- mult_en is 0 in IDLE, RESP and HALT. Dropping it on the done cycle keeps the core parked in its load state.
- Arithmetic is performed by the core: two's complement, WIDTH x WIDTH -> 2*WIDTH.
  - -2^(WIDTH-1) squared = 2^(2*WIDTH-2) is representable; no saturation.
- A request whose req_valid drops before grant is simply not granted. Requesters must hold valid and operands until req_ready.

## Timing
- Reset values: state=IDLE, ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_m=0, rsp_err=0, fault=0, mult_en=0, mult_a=0, mult_b=0, wait counter=0.
- Grant at cycle g → ISSUE at g+1 → mult_done seen at g+WIDTH+4 → rsp_valid rises at g+WIDTH+5.
  - This is 13 cycles for WIDTH=8.
  - The core latency is WIDTH+3 cycles from mult_en rise to done.
- A response accepted at cycle r gives IDLE at r+1, so the earliest next grant is r+1. There is no overlap between operations.
- Back-to-back worst case: NREQ requesters all waiting are each served within NREQ*(WIDTH+6) cycles when rsp_ready is held at 1.
- The wait counter clears on entry to ISSUE and increments every WAIT cycle.
- If mult_done and timeout occur in the same cycle, done wins: normal result, no fault.
- rst_n asserted mid-operation: all state returns to reset values immediately. Any in-flight result is lost with no response. The core must be reset by the same rst_n.

## Test plan
- Single request: req1 with a=3, b=5; others idle → req_ready=4'b0010 at cycle g; rsp_valid at g+13 with rsp_id=1, rsp_m=15, rsp_err=0.
- Signed corners: (-7)×6 → rsp_m=16'hFFD6. (-128)×(-128) → 16'h4000. 127×(-128) → 16'hC080. 0×(-1) → 0.
- Round robin: all four valid continuously, rsp_ready=1 → grant order 0,1,2,3,0; each rsp_id matches its operands; ptr wraps from 3 to 0.
- Backpressure: hold rsp_ready=0 for 20 cycles after rsp_valid → rsp_valid, rsp_id and rsp_m stay stable; req_ready stays 0; mult_en stays 0; the next grant comes exactly 1 cycle after acceptance.
- Stale done: hold mult_done=1 through IDLE, then issue → the ISSUE cycle ignores done; the correct product is returned.
- Timeout and reset: force mult_done=0 → rsp_err=1, rsp_m=0, and fault=1 after 64 WAIT cycles; then HALT with no further grants. Pulse rst_n low mid-WAIT in a separate run → all outputs return to 0 and ptr=0.

Source files
------------

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: round-robin controller sharing one multi-cycle signed multiplier core
// among NREQ requesters. One operation is in flight at a time; the product comes back on a
// valid/ready response channel tagged with the requester ID. A watchdog aborts a WAIT that
// never sees mult_done and latches a sticky fault, after which the controller halts.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester handshake; req_ready is one-hot and only in IDLE
//   req_a, req_b           packed operands, slice i belongs to requester i
//   rsp_valid/rsp_ready    response handshake
//   rsp_id, rsp_m, rsp_err response ID, signed product, timeout-abort flag (rsp_m is 0)
//   fault                  sticky core-timeout flag
//   mult_en, mult_a/b      core enable and operands (operands held for the whole operation)
//   mult_done, mult_m      core done flag (may be stale high while idle) and product
module mult_share_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]    rsp_m,
  output logic                  rsp_err,
  output logic                  fault,
  output logic                  mult_en,
  output logic [WIDTH-1:0]      mult_a,
  output logic [WIDTH-1:0]      mult_b,
  input  logic                  mult_done,
  input  logic [2*WIDTH-1:0]    mult_m
);

  // Wide enough to hold TIMEOUT itself after the final WAIT increment.
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StHalt} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] m_q, m_d;
  logic               err_q, err_d;
  logic               fault_q, fault_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               gnt_found;
  logic [IDW-1:0]     gnt_idx;
  logic               grant;
  logic               timeout;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!gnt_found && req_valid[(32'(ptr_q) + k) % NREQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'((32'(ptr_q) + k) % NREQ);
      end
    end
  end

  assign grant   = (state_q == StIdle) && !fault_q && gnt_found;
  // Evaluated only in WAIT: this is the TIMEOUT-th WAIT cycle.
  assign timeout = (cnt_q == CW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Done takes priority over a coincident timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant) state_d = StIssue;
      // mult_done is ignored here: it may still be high from the previous operation.
      StIssue: state_d = StWait;
      StWait:  if (mult_done || timeout) state_d = StResp;
      StResp:  if (rsp_ready) state_d = fault_q ? StHalt : StIdle;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    req_ready = '0;
    mult_en   = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      StIdle:  if (grant) req_ready = NREQ'(1) << gnt_idx;
      StIssue: mult_en = 1'b1;
      // Dropping enable on the done cycle parks the core; an abort never re-kicks it.
      StWait:  mult_en = !mult_done && !timeout;
      StResp:  rsp_valid = 1'b1;
      StHalt:  ;
      default: ;
    endcase
  end

  // Datapath next-state: operand/ID capture on grant, result capture leaving WAIT.
  always_comb begin
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    err_d   = err_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    if (grant) begin
      a_d   = req_a[32'(gnt_idx) * WIDTH +: WIDTH];
      b_d   = req_b[32'(gnt_idx) * WIDTH +: WIDTH];
      id_d  = gnt_idx;
      ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      cnt_d = '0;
    end
    if (state_q == StWait) begin
      cnt_d = cnt_q + 1'b1;
      if (mult_done) begin
        m_d   = mult_m;
        err_d = 1'b0;
      end else if (timeout) begin
        m_d     = '0;
        err_d   = 1'b1;
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      err_q   <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      err_q   <= err_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_id  = id_q;
  assign rsp_m   = m_q;
  assign rsp_err = err_q;
  assign fault   = fault_q;
  assign mult_a  = a_q;
  assign mult_b  = b_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: a behavioural core stand-in plus a cycle-level reference model
// (busy flag, grant cycle, round-robin pointer, expected product) checked every cycle.
module tb_mult_share_ctrl;

  localparam int WIDTH   = 8;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 64;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid, rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [2*WIDTH-1:0]    rsp_m;
  logic                  rsp_err, fault, mult_en, mult_done;
  logic [WIDTH-1:0]      mult_a, mult_b;
  logic [2*WIDTH-1:0]    mult_m;

  always #5 clk = ~clk;

  mult_share_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_m(rsp_m),
    .rsp_err(rsp_err), .fault(fault),
    .mult_en(mult_en), .mult_a(mult_a), .mult_b(mult_b),
    .mult_done(mult_done), .mult_m(mult_m)
  );

  logic [WIDTH-1:0] ra[NREQ];
  logic [WIDTH-1:0] rb[NREQ];

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = ra[i];
      req_b[i*WIDTH +: WIDTH] = rb[i];
    end
  end

  // Core stand-in: done rises WIDTH+3 cycles after enable is first seen and stays high
  // (stale) until the next start.
  logic               core_run, core_done;
  int                 core_cnt;
  logic [WIDTH-1:0]   core_a, core_b;
  logic [2*WIDTH-1:0] core_m;
  logic               kill, stale_force;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_run <= 1'b0; core_done <= 1'b0; core_cnt <= 0; core_m <= '0;
      core_a <= '0; core_b <= '0;
    end else if (core_run) begin
      if (core_cnt == WIDTH + 2) begin
        core_done <= 1'b1;
        core_m    <= $signed(core_a) * $signed(core_b);
        core_run  <= 1'b0;
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end else if (mult_en) begin
      core_run  <= 1'b1;
      core_cnt  <= 1;
      core_a    <= mult_a;
      core_b    <= mult_b;
      core_done <= 1'b0;
    end
  end

  assign mult_done = kill ? 1'b0 : (core_done | stale_force);
  assign mult_m    = core_m;

  // Reference model state.
  int                 n_cmp, n_fail, cyc, g, op_lat, mptr, n_acc, op_id;
  logic               busy, op_err, fault_m, refill, rnd, rdy_rand;
  logic [WIDTH-1:0]   op_a, op_b;
  logic [2*WIDTH-1:0] op_m;
  logic [NREQ-1:0]    gq[$];

  logic [WIDTH-1:0]   ca_t[4] = '{8'hF9, 8'h80, 8'h7F, 8'h00};
  logic [WIDTH-1:0]   cb_t[4] = '{8'h06, 8'h80, 8'h80, 8'hFF};
  logic [2*WIDTH-1:0] cm_t[4] = '{16'hFFD6, 16'h4000, 16'hC080, 16'h0000};

  function automatic logic [2*WIDTH-1:0] prod(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    longint sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return (2*WIDTH)'(sa * sb);
  endfunction

  function automatic int rr_pick(logic [NREQ-1:0] v, int p);
    for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic post(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    ra[i] = a;
    rb[i] = b;
    req_valid[i] = 1'b1;
  endtask

  // One clock cycle: drive, check against the model, clock, update the model.
  task automatic cycle();
    int d, pick;
    logic exp_rv, exp_en, acc;
    logic [NREQ-1:0] exp_rr;
    if (stale_force && busy && (cyc - g) >= 2) stale_force = 1'b0;
    if (rnd) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(3) == 0)
          post(i, WIDTH'($urandom), WIDTH'($urandom));
    end
    if (rdy_rand) rsp_ready = ($urandom_range(3) != 0);
    #1;
    d = cyc - g;
    if (busy && op_err && d >= op_lat) fault_m = 1'b1;
    exp_rv = busy && d >= op_lat;
    exp_en = busy && d >= 1 && d <= op_lat - 2;
    pick   = (!busy && !fault_m) ? rr_pick(req_valid, mptr) : -1;
    exp_rr = (pick >= 0) ? (NREQ'(1) << pick) : '0;
    chk("req_ready", req_ready, exp_rr);
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("mult_en", mult_en, exp_en);
    chk("fault", fault, fault_m);
    if (exp_rv) begin
      chk("rsp_id", rsp_id, op_id);
      chk("rsp_m", rsp_m, op_m);
      chk("rsp_err", rsp_err, op_err);
    end
    if (busy && d >= 1) begin
      chk("mult_a", mult_a, op_a);
      chk("mult_b", mult_b, op_b);
    end
    if (req_ready != '0) gq.push_back(req_ready);
    acc = exp_rv && rsp_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      busy = 1'b0;
      n_acc++;
    end
    if (pick >= 0) begin
      busy   = 1'b1;
      g      = cyc - 1;
      op_id  = pick;
      op_a   = ra[pick];
      op_b   = rb[pick];
      op_err = kill;
      op_lat = kill ? TIMEOUT + 2 : WIDTH + 5;
      op_m   = kill ? '0 : prod(op_a, op_b);
      mptr   = (pick + 1) % NREQ;
      if (refill) post(pick, WIDTH'($urandom), WIDTH'($urandom));
      else req_valid[pick] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; kill = 1'b0; stale_force = 1'b0; refill = 1'b0;
    rnd = 1'b0; rdy_rand = 1'b0; rsp_ready = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_m", rsp_m, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_fault", fault, 0);
    chk("rst_mult_en", mult_en, 0);
    chk("rst_mult_a", mult_a, 0);
    chk("rst_mult_b", mult_b, 0);
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    busy = 1'b0; mptr = 0; fault_m = 1'b0;
  endtask

  task automatic wait_rsp(input int budget);
    for (int k = 0; k < budget && !rsp_valid; k++) cycle();
    chk("rsp_arrives", rsp_valid, 1'b1);
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && (busy || req_valid != '0); k++) cycle();
    chk("drain_idle", rsp_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n0;
    n_cmp = 0; n_fail = 0; cyc = 0; g = 0; n_acc = 0; op_lat = 0; op_id = 0;
    busy = 1'b0; op_err = 1'b0; fault_m = 1'b0; mptr = 0;
    op_a = '0; op_b = '0; op_m = '0;
    for (int i = 0; i < NREQ; i++) begin ra[i] = '0; rb[i] = '0; end
    rst_n = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    kill = 1'b0; stale_force = 1'b0; refill = 1'b0; rnd = 1'b0; rdy_rand = 1'b0;
    #2;
    do_reset();

    // Single request on requester 1.
    post(1, 8'd3, 8'd5);
    #1;
    chk("single_grant", req_ready, 4'b0010);
    wait_rsp(40);
    chk("single_lat", cyc - g, WIDTH + 5);
    chk("single_id", rsp_id, 1);
    chk("single_m", rsp_m, 16'd15);
    chk("single_err", rsp_err, 0);
    cycle();

    // Signed corners.
    for (int k = 0; k < 4; k++) begin
      post(k, ca_t[k], cb_t[k]);
      wait_rsp(40);
      chk("corner_m", rsp_m, cm_t[k]);
      chk("corner_id", rsp_id, k);
      cycle();
    end

    // Done held high through IDLE and ISSUE must not short-circuit the operation.
    drain(50);
    stale_force = 1'b1;
    repeat (3) cycle();
    post(2, 8'hFD, 8'h09);
    wait_rsp(40);
    chk("stale_lat", cyc - g, WIDTH + 5);
    chk("stale_m", rsp_m, 16'hFFE5);
    cycle();

    // Round robin from reset: all requesters continuously valid.
    drain(50);
    do_reset();
    refill = 1'b1;
    for (int i = 0; i < NREQ; i++) post(i, WIDTH'($urandom), WIDTH'($urandom));
    gq.delete();
    n0 = n_acc;
    for (int k = 0; k < 200 && n_acc < n0 + 5; k++) cycle();
    chk("rr_count", n_acc - n0, 5);
    chk("rr_grants", gq.size() >= 5, 1);
    for (int k = 0; k < 5 && k < gq.size(); k++) chk("rr_order", gq[k], NREQ'(1) << (k % NREQ));
    refill = 1'b0;
    req_valid = '0;

    // Backpressure: response held for 20 cycles, next grant right after acceptance.
    rsp_ready = 1'b0;
    post(0, 8'h11, 8'hEE);
    post(3, 8'h80, 8'h7F);
    wait_rsp(40);
    chk("bp_first_id", rsp_id, 3);
    repeat (20) cycle();
    chk("bp_held_valid", rsp_valid, 1);
    chk("bp_held_m", rsp_m, 16'hC080);
    rsp_ready = 1'b1;
    cycle();
    #1;
    chk("bp_regrant", req_ready, 4'b0001);
    drain(60);

    // Randomised traffic with random backpressure.
    rnd = 1'b1;
    rdy_rand = 1'b1;
    repeat (1500) cycle();
    rnd = 1'b0;
    rdy_rand = 1'b0;
    rsp_ready = 1'b1;
    drain(200);

    // Reset in the middle of WAIT: no response, pointer back to 0.
    post(2, 8'd5, 8'd6);
    for (int k = 0; k < 40 && !(busy && (cyc - g) == 5); k++) cycle();
    chk("mid_wait_en", mult_en, 1);
    do_reset();
    for (int i = 0; i < NREQ; i++) post(i, WIDTH'($urandom), WIDTH'($urandom));
    #1;
    chk("rst_ptr", req_ready, 4'b0001);
    drain(200);

    // Core that never finishes: abort, fault, then halt.
    kill = 1'b1;
    post(1, 8'd7, 8'd7);
    wait_rsp(100);
    chk("to_lat", cyc - g, TIMEOUT + 2);
    chk("to_err", rsp_err, 1);
    chk("to_m", rsp_m, 0);
    chk("to_fault", fault, 1);
    cycle();
    for (int i = 0; i < NREQ; i++) post(i, WIDTH'($urandom), WIDTH'($urandom));
    repeat (20) cycle();
    #1;
    chk("halt_no_grant", req_ready, 0);
    chk("halt_fault", fault, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
